// File: rtl/branch_seq.sv
// Branch-instruction sequencer: walks T3..T6 issuing datapath strobes, loads PC only
// when the latched CON condition is true, and keeps taken / not-taken statistics.
module branch_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stall,
  input  logic             con,
  input  logic             stats_clr,
  output logic             gra,
  output logic             r_out,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;
  logic             finish;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      taken_q      <= taken_d;
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  // A start coinciding with the done pulse is dropped; the decoder re-presents it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !stall && !done_q) state_d = T3;
      T3:      if (!stall) state_d = T4;
      T4:      if (!stall) state_d = T5;
      T5:      if (!stall) state_d = T6;
      T6:      if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign finish = (state_q == T6) && !stall;

  always_comb begin
    done_d       = finish;
    taken_d      = taken_q;
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (finish) begin
      taken_d = con;
      if (con) taken_cnt_d  = taken_cnt_q + CNT_W'(1);
      else     ntaken_cnt_d = ntaken_cnt_q + CNT_W'(1);
    end
    // Clearing the statistics overrides a same-edge increment.
    if (stats_clr) begin
      taken_cnt_d  = '0;
      ntaken_cnt_d = '0;
    end
  end

  // Strobes are pure state decodes so they hold steady through a stall.
  always_comb begin
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    unique case (state_q)
      T3: begin
        gra    = 1'b1;
        r_out  = 1'b1;
        con_in = 1'b1;
      end
      T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
      end
      T6: begin
        zlow_out = 1'b1;
        pc_in    = con;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign taken      = taken_q;
  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;

endmodule

// File: tb/tb_branch_seq.sv
// Randomised self-checking bench for branch_seq against a cycle-level behavioural model
// of the branch instruction timeline (with 4-bit counters so wrap-around is reachable).
module tb_branch_seq;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic             con = 1'b0;
  logic             stats_clr = 1'b0;
  logic             gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in;
  logic             busy, done, taken;
  logic [CNT_W-1:0] taken_cnt, ntaken_cnt;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model: phase 0 = no instruction, 1..4 = steps T3..T6 of the branch
  int phase = 0;
  bit doneExp = 0;
  bit takenExp = 0;
  int takenCntExp = 0;
  int ntakenCntExp = 0;

  branch_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .clear(clear), .start(start), .stall(stall), .con(con),
    .stats_clr(stats_clr), .gra(gra), .r_out(r_out), .con_in(con_in),
    .pc_out(pc_out), .y_in(y_in), .c_out(c_out), .alu_add(alu_add), .z_in(z_in),
    .zlow_out(zlow_out), .pc_in(pc_in), .busy(busy), .done(done), .taken(taken),
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Strobe vector order: gra r_out con_in pc_out y_in c_out alu_add z_in zlow_out pc_in
  function automatic logic [9:0] expectedStrobes(input int p, input bit c);
    case (p)
      1:       return 10'b1110000000;
      2:       return 10'b0001100000;
      3:       return 10'b0000011100;
      4:       return {9'b000000001, c};
      default: return 10'b0;
    endcase
  endfunction

  function automatic void modelReset();
    phase = 0;
    doneExp = 0;
    takenExp = 0;
    takenCntExp = 0;
    ntakenCntExp = 0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit st, input bit sl, input bit cn, input bit sc,
                               input bit clr_n);
    bit finished;
    @(negedge clk);
    start = st;
    stall = sl;
    con = cn;
    stats_clr = sc;
    clear = clr_n;
    if (!clr_n) modelReset();
    #1;
    checkOutput("strobes", 32'({gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
                                zlow_out, pc_in}), 32'(expectedStrobes(phase, cn)));
    checkOutput("busy", 32'(busy), 32'(phase != 0));
    checkOutput("done", 32'(done), 32'(doneExp));
    checkOutput("taken", 32'(taken), 32'(takenExp));
    checkOutput("taken_cnt", 32'(taken_cnt), 32'(takenCntExp));
    checkOutput("ntaken_cnt", 32'(ntaken_cnt), 32'(ntakenCntExp));
    @(posedge clk);
    if (clr_n) begin
      finished = (phase == 4) && !sl;
      if (finished) begin
        takenExp = cn;
        if (cn) takenCntExp = (takenCntExp + 1) % CNT_MOD;
        else    ntakenCntExp = (ntakenCntExp + 1) % CNT_MOD;
      end
      if (sc) begin
        takenCntExp = 0;
        ntakenCntExp = 0;
      end
      if (phase == 0) begin
        if (st && !sl && !doneExp) phase = 1;
      end else if (!sl) begin
        phase = (phase == 4) ? 0 : phase + 1;
      end
      doneExp = finished;
    end
  endtask

  task automatic runBranch(input bit cn);
    applyStimulus(1, 0, cn, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, cn, 0, 1);
  endtask

  initial begin
    // Reset, then taken and not-taken branches
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    runBranch(1);
    runBranch(0);

    // Stall three cycles in T4
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1);

    // Reset during T5, then a clean branch
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    runBranch(1);

    // Counter wrap: 16 more taken branches from a count of 1
    for (int i = 0; i < CNT_MOD; i++) runBranch(1);
    checkOutput("wrap_taken_cnt", 32'(taken_cnt), 32'd1);

    // stats_clr on the T6->IDLE edge beats the increment
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clr_ntaken_cnt", 32'(ntaken_cnt), 32'd0);

    // start held high continuously
    for (int i = 0; i < 30; i++) applyStimulus(1, 0, i[3], 0, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 40) == 0,
                    $urandom_range(0, 150) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
